// File: rtl/tile_map_draw_if.sv
// Bundle of tile_map_draw's control, map RAM, sprite ROM and pixel-stream signals.
// The engine connects to the slave modport; the game FSM/memories/VGA side connects to the master modport.
interface tile_map_draw_if #(
    parameter int ID_W     = 3,
    parameter int COLOUR_W = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int MAP_AW   = 9,
    parameter int ROM_AW   = 9
) ();
    logic                start;
    logic                mode;
    logic [4:0]          cell_col;
    logic [3:0]          cell_row;
    logic [MAP_AW-1:0]   map_addr;
    logic [ID_W-1:0]     map_id;
    logic [ROM_AW-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_colour;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport slave (
        input  start, mode, cell_col, cell_row, map_id, rom_colour,
        output map_addr, rom_addr, x, y, colour, plot, busy, done
    );

    modport master (
        output start, mode, cell_col, cell_row, map_id, rom_colour,
        input  map_addr, rom_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/tile_map_draw.sv
// Tile-map draw engine: redraws the whole level map or one cell, streaming sprite pixels to the VGA adapter.
// Optional build macro TILE_TRANSPARENT_EN suppresses plots of pixels whose colour equals KEY_COLOUR.
module tile_map_draw #(
    parameter int TILE_W    = 8,
    parameter int TILE_H    = 8,
    parameter int GRID_COLS = 20,
    parameter int GRID_ROWS = 15,
    parameter int ID_W      = 3,
    parameter int COLOUR_W  = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int MAP_AW    = 9
`ifdef TILE_TRANSPARENT_EN
    , parameter int KEY_COLOUR = 0
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    tile_map_draw_if.slave    bus
);
    localparam int PX_W   = $clog2(TILE_W);
    localparam int PY_W   = $clog2(TILE_H);
    localparam int ROM_AW = ID_W + PY_W + PX_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAP_REQ  = 3'd1,
        S_MAP_WAIT = 3'd2,
        S_PIXELS   = 3'd3,
        S_FLUSH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [4:0]          r_col;
    logic [3:0]          r_row;
    logic [ID_W-1:0]     r_id;
    logic [PX_W-1:0]     r_px;
    logic [PY_W-1:0]     r_py;
    logic [MAP_AW-1:0]   r_map_addr;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_pvalid;
    logic [X_W-1:0]      r_xp;
    logic [Y_W-1:0]      r_yp;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;

    logic                w_plot;
    logic                w_px_wrap;
    logic                w_last_pix;
    logic                w_last_cell;
    logic                w_cell_oob;
    logic [PX_W-1:0]     w_px_next;
    logic [PY_W-1:0]     w_py_next;

    assign w_px_wrap   = (r_px == PX_W'(TILE_W - 1));
    assign w_last_pix  = w_px_wrap && (r_py == PY_W'(TILE_H - 1));
    assign w_px_next   = r_px + PX_W'(1);
    assign w_py_next   = w_px_wrap ? (r_py + PY_W'(1)) : r_py;
    assign w_last_cell = (32'(r_col) == 32'(GRID_COLS - 1)) && (32'(r_row) == 32'(GRID_ROWS - 1));
    assign w_cell_oob  = (32'(bus.cell_col) >= 32'(GRID_COLS)) || (32'(bus.cell_row) >= 32'(GRID_ROWS));

    // The ROM word arrives in the plot cycle itself, so colour is taken straight from it while plotting.
`ifdef TILE_TRANSPARENT_EN
    assign w_plot = r_pvalid && (bus.rom_colour != COLOUR_W'(KEY_COLOUR));
`else
    assign w_plot = r_pvalid;
`endif

    assign bus.plot     = w_plot;
    assign bus.x        = w_plot ? r_xp : r_x;
    assign bus.y        = w_plot ? r_yp : r_y;
    assign bus.colour   = w_plot ? bus.rom_colour : r_colour;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.map_addr = r_map_addr;
    assign bus.rom_addr = r_rom_addr;

    // Control FSM, cell/pixel counters and the pixel pipeline register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_col      <= 5'd0;
            r_row      <= 4'd0;
            r_id       <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_map_addr <= '0;
            r_rom_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pvalid   <= 1'b0;
            r_xp       <= '0;
            r_yp       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_pvalid <= 1'b0;
            if (w_plot) begin
                r_x      <= r_xp;
                r_y      <= r_yp;
                r_colour <= bus.rom_colour;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        if (!bus.mode) begin
                            r_col      <= 5'd0;
                            r_row      <= 4'd0;
                            r_map_addr <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_MAP_REQ;
                        end else if (w_cell_oob) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_col      <= bus.cell_col;
                            r_row      <= bus.cell_row;
                            r_map_addr <= MAP_AW'(32'(bus.cell_row) * 32'(GRID_COLS) + 32'(bus.cell_col));
                            r_busy     <= 1'b1;
                            r_state    <= S_MAP_REQ;
                        end
                    end
                end
                S_MAP_REQ: r_state <= S_MAP_WAIT;
                S_MAP_WAIT: begin
                    r_id       <= bus.map_id;
                    r_px       <= '0;
                    r_py       <= '0;
                    r_rom_addr <= {bus.map_id, {PY_W{1'b0}}, {PX_W{1'b0}}};
                    r_state    <= S_PIXELS;
                end
                S_PIXELS: begin
                    r_pvalid <= 1'b1;
                    r_xp     <= X_W'(32'(r_col) * 32'(TILE_W) + 32'(r_px));
                    r_yp     <= Y_W'(32'(r_row) * 32'(TILE_H) + 32'(r_py));
                    if (!w_last_pix) begin
                        r_px       <= w_px_next;
                        r_py       <= w_py_next;
                        r_rom_addr <= {r_id, w_py_next, w_px_next};
                    end else if (r_mode || w_last_cell) begin
                        r_state <= S_FLUSH;
                    end else begin
                        // Cells are visited row-major, so the map address simply increments.
                        r_map_addr <= r_map_addr + MAP_AW'(1);
                        if (32'(r_col) == 32'(GRID_COLS - 1)) begin
                            r_col <= 5'd0;
                            r_row <= r_row + 4'd1;
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                        r_state <= S_MAP_REQ;
                    end
                end
                S_FLUSH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
